ad9516_cfg_sequencer: RTL and testbench

- Power-up/configuration sequencer for the two AD9516 clock chips on the board.
- Drives each chip's RESET_B and PD_B and walks a register table in a synchronous ROM.
- Issues every table entry through a single shared SPI master using a req/ack handshake, then commits the update and waits for PLL lock on STATUS.
- Configures chip 1 then chip 2, serially, with a per-chip retry on lock timeout.

---
 rtl/ad9516_cfg_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_ad9516_cfg_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9516_cfg_sequencer.sv
// Power-up and register-table sequencer for the two on-board AD9516 clock chips.
// Define AD9516_READBACK_EN to read back and verify every table write.
module ad9516_cfg_sequencer #(
  parameter int RST_PULSE_CYC    = 1000,
  parameter int RST_WAIT_CYC     = 10000,
  parameter int LOCK_TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY        = 3,
  parameter int TBL_AW           = 7
) (
  input  logic              sys_clk_i,
  input  logic              hw_arst,
  input  logic              start_i,
  input  logic [1:0]        chip_en_i,
  output logic [1:0]        rst_b_o,
  output logic [1:0]        pd_b_o,
  input  logic [1:0]        status_i,
  output logic [TBL_AW-1:0] tbl_addr_o,
  input  logic [17:0]       tbl_data_i,
  output logic              spi_req_o,
  output logic              spi_sel_o,
  output logic              spi_rnw_o,
  output logic [9:0]        spi_addr_o,
  output logic [7:0]        spi_wdata_o,
  input  logic              spi_ack_i,
  input  logic [7:0]        spi_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        locked_o,
  output logic [1:0]        err_o
);

  localparam int CMAX0 = (RST_PULSE_CYC > RST_WAIT_CYC) ?
                         RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int CMAX  = (CMAX0 > LOCK_TIMEOUT_CYC) ?
                         CMAX0 : LOCK_TIMEOUT_CYC;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_RST_LOW, S_RST_WAIT,
    S_TBL_RD, S_TBL_LAT, S_SPI_REQ, S_SPI_WAIT,
    S_RB_REQ, S_RB_WAIT, S_UPDATE, S_UPD_WAIT,
    S_LOCK_WAIT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        en_q, proc_q, rst_b_q;
  logic [1:0]        status_s1, status_s2;
  logic [1:0]        locked_q, err_q;
  logic              sel_q, req_q, busy_q, done_q;
  logic [CW-1:0]     cnt_q;
  logic [RW-1:0]     retry_q;
  logic [TBL_AW-1:0] tbl_addr_q;
  logic [9:0]        addr_q;
  logic [7:0]        wdata_q;

  logic [1:0] pend;
  logic       pick, ack_ok, is_end, addr_last;
  logic       pulse_hit, wait_hit, lock_hit, lock_ok, can_retry;

  assign pend      = en_q & ~proc_q;
  assign pick      = ~pend[0];
  assign ack_ok    = spi_ack_i & req_q;
  assign is_end    = tbl_data_i[17:8] == 10'h3FF;
  assign addr_last = &tbl_addr_q;
  assign pulse_hit = cnt_q == CW'(RST_PULSE_CYC - 1);
  assign wait_hit  = cnt_q == CW'(RST_WAIT_CYC - 1);
  assign lock_hit  = cnt_q == CW'(LOCK_TIMEOUT_CYC - 1);
  assign lock_ok   = status_s2[sel_q];
  assign can_retry = retry_q < RW'(MAX_RETRY);

`ifdef AD9516_READBACK_EN
  logic rnw_q, rb_bad, addr_zero;
  assign rb_bad    = spi_rdata_i != wdata_q;
  assign addr_zero = tbl_addr_q == '0;
  assign spi_rnw_o = rnw_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^spi_rdata_i;
  assign spi_rnw_o    = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or posedge hw_arst) begin
    if (hw_arst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (start_i)
          state_d = (chip_en_i == 2'b00) ? S_DONE : S_SEL;
      S_SEL:      state_d = (|pend) ? S_RST_LOW : S_DONE;
      S_RST_LOW:  if (pulse_hit) state_d = S_RST_WAIT;
      S_RST_WAIT: if (wait_hit) state_d = S_TBL_RD;
      S_TBL_RD:   state_d = S_TBL_LAT;
      S_TBL_LAT:  state_d = is_end ? S_UPDATE : S_SPI_REQ;
      S_SPI_REQ:  state_d = S_SPI_WAIT;
`ifdef AD9516_READBACK_EN
      S_SPI_WAIT: if (ack_ok) state_d = S_RB_REQ;
      S_RB_REQ:   state_d = S_RB_WAIT;
      S_RB_WAIT:
        if (ack_ok)
          state_d = rb_bad    ? S_SEL :
                    addr_zero ? S_UPDATE : S_TBL_RD;
`else
      S_SPI_WAIT:
        if (ack_ok)
          state_d = addr_last ? S_UPDATE : S_TBL_RD;
`endif
      S_UPDATE:   state_d = S_UPD_WAIT;
      S_UPD_WAIT: if (ack_ok) state_d = S_LOCK_WAIT;
      S_LOCK_WAIT:
        if (lock_ok)
          state_d = S_SEL;
        else if (lock_hit)
          state_d = can_retry ? S_RST_LOW : S_SEL;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge hw_arst) begin
    if (hw_arst) begin
      status_s1  <= '0;
      status_s2  <= '0;
      en_q       <= '0;
      proc_q     <= '0;
      rst_b_q    <= '0;
      locked_q   <= '0;
      err_q      <= '0;
      sel_q      <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      retry_q    <= '0;
      tbl_addr_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef AD9516_READBACK_EN
      rnw_q      <= 1'b0;
`endif
    end else begin
      status_s1 <= status_i;
      status_s2 <= status_s1;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE:
          if (start_i) begin
            en_q     <= chip_en_i;
            proc_q   <= '0;
            locked_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b1;
          end
        S_SEL:
          if (|pend) begin
            sel_q          <= pick;
            proc_q[pick]   <= 1'b1;
            rst_b_q[pick]  <= 1'b0;
            retry_q        <= '0;
            cnt_q          <= '0;
            tbl_addr_q     <= '0;
          end
        S_RST_LOW:
          if (pulse_hit) begin
            cnt_q          <= '0;
            rst_b_q[sel_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        S_RST_WAIT:
          cnt_q <= wait_hit ? '0 : cnt_q + 1'b1;
        S_SPI_REQ: begin
          req_q   <= 1'b1;
          addr_q  <= tbl_data_i[17:8];
          wdata_q <= tbl_data_i[7:0];
        end
        S_SPI_WAIT:
          if (ack_ok) begin
            req_q      <= 1'b0;
            tbl_addr_q <= tbl_addr_q + 1'b1;
          end
`ifdef AD9516_READBACK_EN
        S_RB_REQ: begin
          req_q <= 1'b1;
          rnw_q <= 1'b1;
        end
        S_RB_WAIT:
          if (ack_ok) begin
            req_q <= 1'b0;
            rnw_q <= 1'b0;
            if (rb_bad) err_q[sel_q] <= 1'b1;
          end
`endif
        S_UPDATE: begin
          req_q   <= 1'b1;
          addr_q  <= 10'h232;
          wdata_q <= 8'h01;
        end
        S_UPD_WAIT:
          if (ack_ok) begin
            req_q <= 1'b0;
            cnt_q <= '0;
          end
        S_LOCK_WAIT:
          if (lock_ok) begin
            locked_q[sel_q] <= 1'b1;
          end else if (lock_hit) begin
            cnt_q <= '0;
            if (can_retry) begin
              // next attempt restarts the reset pulse and the table
              retry_q        <= retry_q + 1'b1;
              tbl_addr_q     <= '0;
              rst_b_q[sel_q] <= 1'b0;
            end else begin
              err_q[sel_q] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rst_b_o     = rst_b_q;
  assign pd_b_o      = 2'b11;
  assign tbl_addr_o  = tbl_addr_q;
  assign spi_req_o   = req_q;
  assign spi_sel_o   = sel_q;
  assign spi_addr_o  = addr_q;
  assign spi_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign locked_o    = locked_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ad9516_cfg_sequencer.sv
// Bench for ad9516_cfg_sequencer: table vectors, random runs vs a
// transaction-level model, plus directed reset/handshake corner cases.
module tb_ad9516_cfg_sequencer;

  localparam int P_PULSE = 8;
  localparam int P_WAIT  = 12;
  localparam int P_TO    = 600;
  localparam int P_RETRY = 1;
  localparam int P_AW    = 4;

  logic        clk = 1'b0;
  logic        hw_arst, start, spi_ack, spur;
  logic [1:0]  chip_en, rst_b, pd_b, status, locked, err;
  logic [3:0]  tbl_addr;
  logic [17:0] tbl_data;
  logic        spi_req, spi_sel, spi_rnw, busy, done;
  logic [9:0]  spi_addr;
  logic [7:0]  spi_wdata, spi_rdata;

  always #5 clk = ~clk;

  logic [17:0] rom [16];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  ad9516_cfg_sequencer #(
    .RST_PULSE_CYC(P_PULSE), .RST_WAIT_CYC(P_WAIT),
    .LOCK_TIMEOUT_CYC(P_TO), .MAX_RETRY(P_RETRY),
    .TBL_AW(P_AW)
  ) dut (
    .sys_clk_i(clk), .hw_arst(hw_arst),
    .start_i(start), .chip_en_i(chip_en),
    .rst_b_o(rst_b), .pd_b_o(pd_b),
    .status_i(status),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .spi_req_o(spi_req), .spi_sel_o(spi_sel),
    .spi_rnw_o(spi_rnw), .spi_addr_o(spi_addr),
    .spi_wdata_o(spi_wdata),
    .spi_ack_i(spi_ack | spur), .spi_rdata_i(spi_rdata),
    .busy_o(busy), .done_o(done),
    .locked_o(locked), .err_o(err)
  );

  typedef struct packed {
    logic       sel;
    logic       rnw;
    logic [9:0] addr;
    logic [7:0] data;
  } xfer_t;

  typedef struct {
    logic [1:0] en;
    int         len;
    int         lk0;
    int         lk1;
    int         sdly;
    int         adly;
    logic [1:0] xl;
    logic [1:0] xe;
    logic       use_model;
  } vec_t;

  xfer_t got_q[$], exp_q[$];
  int vecs = 0, errs = 0;
  int ack_dly = 1, sdly = 1, stab_err = 0, done_cnt = 0;
  int lk[2], att[2], scnt[2], rise[2], lowlen[2], lastlow[2];
  int mpul[2];
  logic [1:0] mxl, mxe, exp_rstb, fresh, prev_rst;
  logic       bad_on = 1'b0;
  logic [7:0] bad_val = 8'h18;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // SPI slave, status driver
  initial begin
    int wcnt;
    xfer_t cap, cur;
    logic [7:0] last_w;
    wcnt = 0; last_w = 0;
    spi_ack = 1'b0; spi_rdata = 8'h00;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++)
        if (scnt[c] > 0) begin
          scnt[c]--;
          if (scnt[c] == 0) status[c] = 1'b1;
        end
      cur = {spi_sel, spi_rnw, spi_addr, spi_wdata};
      if (hw_arst) begin
        spi_ack = 1'b0; wcnt = 0;
      end else if (spi_ack) begin
        spi_ack = 1'b0; wcnt = 0;
      end else if (spi_req) begin
        if (wcnt == 0) cap = cur;
        else if (cur !== cap) stab_err++;
        if (wcnt >= ack_dly - 1) begin
          spi_ack = 1'b1; wcnt = 0;
          got_q.push_back(cur);
          if (cur.rnw)
            spi_rdata = (bad_on && !cur.sel && last_w == bad_val) ?
                        8'hFF : last_w;
          else
            last_w = cur.data;
          if (!cur.rnw && cur.addr == 10'h232) begin
            att[cur.sel]++;
            if (att[cur.sel] - 1 == lk[cur.sel]) scnt[cur.sel] = sdly;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // done pulses and RESET_B pulse shape
  initial begin
    prev_rst = 2'b00;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      for (int c = 0; c < 2; c++) begin
        if (!rst_b[c]) begin
          if (prev_rst[c]) lowlen[c] = 1;
          else if (lowlen[c] > 0) lowlen[c]++;
        end else begin
          if (!prev_rst[c]) begin
            rise[c]++;
            lastlow[c] = lowlen[c];
          end
          lowlen[c] = 0;
        end
        prev_rst[c] = rst_b[c];
      end
    end
  end

  // expected SPI transaction list and flags, from the table contents
  task automatic model(input vec_t v);
    int n, lkc;
    logic [17:0] e;
    logic rbf;
    exp_q.delete();
    mxl = 2'b00; mxe = 2'b00; mpul[0] = 0; mpul[1] = 0;
    n = (v.len < 16) ? v.len : 16;
    for (int c = 0; c < 2; c++) begin
      if (!v.en[c]) continue;
      lkc = (c == 0) ? v.lk0 : v.lk1;
      for (int a = 0; a <= P_RETRY; a++) begin
        mpul[c]++;
        rbf = 1'b0;
        for (int i = 0; i < n; i++) begin
          e = rom[i];
          exp_q.push_back({c[0], 1'b0, e[17:8], e[7:0]});
`ifdef AD9516_READBACK_EN
          exp_q.push_back({c[0], 1'b1, e[17:8], e[7:0]});
          if (bad_on && c == 0 && e[7:0] == bad_val) begin
            rbf = 1'b1;
            break;
          end
`endif
        end
        if (rbf) begin
          mxe[c] = 1'b1;
          break;
        end
        exp_q.push_back({c[0], 1'b0, 10'h232, 8'h01});
        if (lkc == a) begin
          mxl[c] = 1'b1;
          break;
        end
        if (a == P_RETRY) mxe[c] = 1'b1;
      end
    end
  endtask

  task automatic run_seq(input vec_t v, input string tag);
    logic [1:0] wl, we;
    int k, nc;
    for (int i = 0; i < 16; i++)
      rom[i] = {10'($urandom_range(0, 1022)), 8'($urandom)};
    if (v.len < 16) rom[v.len][17:8] = 10'h3FF;
    if (bad_on) rom[0][7:0] = bad_val;
    model(v);
    wl = v.use_model ? mxl : v.xl;
    we = v.use_model ? mxe : v.xe;
    lk[0] = v.lk0; lk[1] = v.lk1;
    sdly = v.sdly; ack_dly = v.adly;
    att[0] = 0; att[1] = 0; scnt[0] = 0; scnt[1] = 0;
    rise[0] = 0; rise[1] = 0;
    status = 2'b00;
    got_q.delete();
    stab_err = 0; done_cnt = 0;
    @(negedge clk);
    chip_en = v.en; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (done_cnt == 0 && k < 8000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, " done"}, done_cnt, 1);
    chk({tag, " locked"}, locked, wl);
    chk({tag, " err"}, err, we);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " xfers"}, got_q.size(), exp_q.size());
    nc = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nc; i++)
      chk($sformatf("%s xfer%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, " stable"}, stab_err, 0);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s pulses%0d", tag, c), rise[c], mpul[c]);
      if (mpul[c] > 0)
        chk($sformatf("%s plen%0d", tag, c), lastlow[c],
            (fresh[c] && mpul[c] == 1) ? 0 : P_PULSE);
      if (v.en[c]) begin
        fresh[c] = 1'b0;
        exp_rstb[c] = 1'b1;
      end
    end
    chk({tag, " rst_b"}, rst_b, exp_rstb);
  endtask

  vec_t tv[8];
  vec_t rv;

  initial begin
    tv[0] = '{2'b01, 3,  0, -1, 500, 4,  2'b01, 2'b00, 1'b0};
    tv[1] = '{2'b11, 2, -1, -1, 5,   1,  2'b00, 2'b11, 1'b0};
    tv[2] = '{2'b11, 1,  1,  0, 20,  2,  2'b11, 2'b00, 1'b0};
    tv[3] = '{2'b10, 0, -1,  0, 7,   3,  2'b10, 2'b00, 1'b0};
    tv[4] = '{2'b10, 16, -1, -1, 5,  2,  2'b00, 2'b10, 1'b0};
    tv[5] = '{2'b00, 3,  0,  0, 5,   1,  2'b00, 2'b00, 1'b0};
    tv[6] = '{2'b01, 5,  1, -1, 30,  20, 2'b01, 2'b00, 1'b0};
    tv[7] = '{2'b11, 4, -1,  1, 9,   3,  2'b10, 2'b01, 1'b0};
    for (int c = 0; c < 2; c++) begin
      lk[c] = -1; att[c] = 0; scnt[c] = 0;
      rise[c] = 0; lowlen[c] = 0; lastlow[c] = 0;
    end
    for (int i = 0; i < 16; i++) rom[i] = 18'h0;
    fresh = 2'b11; exp_rstb = 2'b00;
    hw_arst = 1'b1; start = 1'b0; chip_en = 2'b00;
    status = 2'b00; spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst rst_b", rst_b, 2'b00);
    chk("rst pd_b", pd_b, 2'b11);
    chk("rst req", spi_req, 0);
    chk("rst spi", {spi_sel, spi_rnw, spi_addr, spi_wdata}, 0);
    chk("rst tbl_addr", tbl_addr, 0);
    chk("rst flags", {busy, done, locked, err}, 0);
    hw_arst = 1'b0;
    @(negedge clk);

    chip_en = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("en00 busy", busy, 1);
    chk("en00 early", done, 0);
    @(negedge clk);
    chk("en00 done", done, 1);
    @(negedge clk);
    chk("en00 one", {done, busy, spi_req}, 0);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur ack", {busy, done, spi_req, tbl_addr}, 0);

    for (int i = 0; i < 8; i++) run_seq(tv[i], $sformatf("tv%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.en = 2'($urandom_range(0, 3));
      rv.len = $urandom_range(0, 16);
      rv.lk0 = $urandom_range(0, 2) - 1;
      rv.lk1 = $urandom_range(0, 2) - 1;
      rv.sdly = $urandom_range(1, 400);
      rv.adly = $urandom_range(1, 6);
      rv.xl = 2'b00; rv.xe = 2'b00;
      rv.use_model = 1'b1;
      run_seq(rv, $sformatf("rnd%0d", i));
    end

`ifdef AD9516_READBACK_EN
    begin
      int n232;
      bad_on = 1'b1;
      run_seq('{2'b11, 2, 0, 0, 10, 2, 2'b10, 2'b01, 1'b0}, "rb");
      bad_on = 1'b0;
      n232 = 0;
      foreach (got_q[i])
        if (!got_q[i].sel && got_q[i].addr == 10'h232) n232++;
      chk("rb no upd c1", n232, 0);
    end
`endif

    begin
      int k;
      for (int i = 0; i < 16; i++) rom[i] = {10'h010 + 10'(i), 8'h5A};
      rom[3] = {10'h3FF, 8'h00};
      ack_dly = 1000; lk[0] = -1; lk[1] = -1;
      status = 2'b00;
      @(negedge clk);
      chip_en = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!spi_req && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("abort req seen", spi_req, 1);
      chip_en = 2'b10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("restart ignored", {busy, spi_req, spi_sel}, 3'b110);
      chk("restart addr", spi_addr, 10'h010);
      hw_arst = 1'b1;
      #1;
      chk("abort rst_b", rst_b, 2'b00);
      chk("abort req", spi_req, 0);
      chk("abort busy", busy, 0);
      @(negedge clk);
      hw_arst = 1'b0;
      ack_dly = 1;
      repeat (2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
